// File: rtl/tdp_bist_pkg.sv
// Shared types and helpers for the TDP RAM18K self-test sequencer.
package tdp_bist_pkg;

  localparam int unsigned W18        = 18;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PAR_W      = 2;
  localparam int unsigned RAM_ADDR_W = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // One 18-bit RAM word: parity in the top two bits, data below.
  typedef struct packed {
    logic [PAR_W-1:0]  parity;
    logic [DATA_W-1:0] data;
  } ram_word_t;

  // Address-seeded test pattern; idx is the zero-extended word index.
  function automatic logic [DATA_W-1:0] bist_pattern(input logic [DATA_W-1:0] idx,
                                                     input logic [DATA_W-1:0] seed);
    return idx ^ seed;
  endfunction

  // Even parity per byte: {upper byte, lower byte}.
  function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] data16);
    return {^data16[15:8], ^data16[7:0]};
  endfunction

endpackage

// File: rtl/tdp_ram18k_bist_ctrl_if.sv
// RAM-side bus between the BIST sequencer (master) and one 18-bit TDP RAM (slave).
interface tdp_ram18k_bist_ctrl_if;
  import tdp_bist_pkg::*;

  logic                  wen_a;
  logic [1:0]            be_a;
  logic [RAM_ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0]     wdata_a;
  logic [PAR_W-1:0]      wparity_a;
  logic                  ren_b;
  logic [RAM_ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0]     rdata_b;
  logic [PAR_W-1:0]      rparity_b;

  modport master (
    output wen_a, be_a, addr_a, wdata_a, wparity_a, ren_b, addr_b,
    input  rdata_b, rparity_b
  );

  modport slave (
    input  wen_a, be_a, addr_a, wdata_a, wparity_a, ren_b, addr_b,
    output rdata_b, rparity_b
  );
endinterface

// File: rtl/tdp_bist_rd_pipe.sv
// Delay line of {valid, expected word}, RD_LATENCY stages deep, aligned to RAM read data.
module tdp_bist_rd_pipe
  import tdp_bist_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  input  ram_word_t in_exp,
  output logic      out_valid,
  output ram_word_t out_exp
);

  localparam int unsigned SW = W18 + 1;

  logic [RD_LATENCY*SW-1:0] line_q;

  if (RD_LATENCY == 1) begin : g_one
    // Single stage: register the entry directly.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line_q <= '0;
      else        line_q <= {in_valid, in_exp};
    end
  end else begin : g_multi
    // Shift a new entry in at the bottom every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line_q <= '0;
      else        line_q <= {line_q[(RD_LATENCY-1)*SW-1:0], in_valid, in_exp};
    end
  end

  assign {out_valid, out_exp} = line_q[RD_LATENCY*SW-1 -: SW];

endmodule

// File: rtl/tdp_ram18k_bist_ctrl.sv
// Write/read-back self-test sequencer for one 18-bit x 1024 RAM of a TDP_RAM18KX2.
// Optional first-failure log enabled by defining TDP_BIST_ERR_LOG_EN.
module tdp_ram18k_bist_ctrl
  import tdp_bist_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ERR_CNT_W  = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef TDP_BIST_ERR_LOG_EN
  output logic                 fail_valid,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [W18-1:0]       fail_exp,
  output logic [W18-1:0]       fail_act,
`endif
  tdp_ram18k_bist_ctrl_if.master ram
);

  bist_state_e           state_q, state_n;
  logic [ADDR_W-1:0]     idx_q, idx_n;
  logic [DATA_W-1:0]     seed_q;
  logic [ERR_CNT_W-1:0]  err_n;
  logic                  busy_n, done_n, pass_n;
  logic                  wen_n, ren_n;
  logic [RAM_ADDR_W-1:0] addr_n;
  ram_word_t             word_n, rd_exp_q, rd_exp_n;
  logic                  accept_c, mismatch_c, pipe_vld;
  ram_word_t             pipe_exp, act_c;

  assign accept_c   = start && !busy && (state_q == IDLE || state_q == DONE);
  assign act_c      = '{parity: ram.rparity_b, data: ram.rdata_b};
  assign mismatch_c = pipe_vld && (act_c != pipe_exp);

  // Expected read words, delayed to meet the RAM read data.
  tdp_bist_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (ram.ren_b),
    .in_exp   (rd_exp_q),
    .out_valid(pipe_vld),
    .out_exp  (pipe_exp)
  );

  // Next state, index, error count and next values of all registered outputs.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q + ADDR_W'(1);
    err_n   = err_cnt;
    case (state_q)
      IDLE, DONE: begin
        idx_n = '0;
        if (accept_c) state_n = WRITE;
      end
      WRITE: if (idx_q == ADDR_W'(DEPTH - 1)) begin
        state_n = READ;
        idx_n   = '0;
      end
      READ: if (idx_q == ADDR_W'(DEPTH - 1)) begin
        state_n = DRAIN;
        idx_n   = '0;
      end
      DRAIN: if (idx_q == ADDR_W'(RD_LATENCY - 1)) begin
        state_n = DONE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase

    if (accept_c)                              err_n = '0;
    else if (mismatch_c && (err_cnt != '1))    err_n = err_cnt + ERR_CNT_W'(1);

    // DONE becomes visible once the last compare has landed in err_cnt.
    done_n = (state_q == DONE) && (state_n == DONE);
    busy_n = (state_n != IDLE) && !done_n;
    pass_n = done_n && (err_n == '0);

    wen_n          = (state_q == WRITE);
    ren_n          = (state_q == READ);
    word_n.data    = bist_pattern(DATA_W'(idx_q), seed_q);
    word_n.parity  = byte_parity(word_n.data);
    addr_n         = RAM_ADDR_W'({idx_q, 4'b0000});
    rd_exp_n       = ren_n ? word_n : '0;
  end

  // State register and registered outputs; reset drops the RAM strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      seed_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      rd_exp_q      <= '0;
      ram.wen_a     <= 1'b0;
      ram.be_a      <= '0;
      ram.addr_a    <= '0;
      ram.wdata_a   <= '0;
      ram.wparity_a <= '0;
      ram.ren_b     <= 1'b0;
      ram.addr_b    <= '0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      if (accept_c) seed_q <= seed;
      busy          <= busy_n;
      done          <= done_n;
      pass          <= pass_n;
      err_cnt       <= err_n;
      rd_exp_q      <= rd_exp_n;
      ram.wen_a     <= wen_n;
      ram.be_a      <= {2{wen_n}};
      ram.addr_a    <= wen_n ? addr_n : '0;
      ram.wdata_a   <= wen_n ? word_n.data : '0;
      ram.wparity_a <= wen_n ? word_n.parity : '0;
      ram.ren_b     <= ren_n;
      ram.addr_b    <= ren_n ? addr_n : '0;
    end
  end

`ifdef TDP_BIST_ERR_LOG_EN
  // Keep the first mismatch of a run; the word index is recovered from the pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
    end else if (accept_c) begin
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_act   <= '0;
    end else if (mismatch_c && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_addr  <= ADDR_W'(pipe_exp.data ^ seed_q);
      fail_exp   <= pipe_exp;
      fail_act   <= act_c;
    end
  end
`endif

endmodule

// File: tb/tb_tdp_ram18k_bist_ctrl.sv
// Bench for tdp_ram18k_bist_ctrl: behavioural 1- and 2-cycle RAM models, write scoreboard,
// run-result queue. Define TDP_BIST_ERR_LOG_EN to also check the first-failure log.
module tb_tdp_ram18k_bist_ctrl;

  localparam int DEPTH = 1024;

  typedef struct {
    int lat;
    int errs;
    bit ok;
  } run_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [15:0] seed = '0, seed2 = '0;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [10:0] err_cnt, err_cnt2;
`ifdef TDP_BIST_ERR_LOG_EN
  logic        fail_valid, fail_valid2;
  logic [9:0]  fail_addr, fail_addr2;
  logic [17:0] fail_exp, fail_act, fail_exp2, fail_act2;
`endif

  int checks = 0;
  int errors = 0;
  run_exp_t    run_q[$];
  logic [33:0] wr_q[$];
  bit fault_d0 = 1'b0;
  bit fault_par = 1'b0;

  tdp_ram18k_bist_ctrl_if bus ();
  tdp_ram18k_bist_ctrl_if bus2 ();

  always #5 clk = ~clk;

  tdp_ram18k_bist_ctrl #(.DEPTH(1024), .ADDR_W(10), .RD_LATENCY(1), .ERR_CNT_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
`ifdef TDP_BIST_ERR_LOG_EN
    .fail_valid(fail_valid), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
`endif
    .ram(bus)
  );

  tdp_ram18k_bist_ctrl #(.DEPTH(1024), .ADDR_W(10), .RD_LATENCY(2), .ERR_CNT_W(11)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
`ifdef TDP_BIST_ERR_LOG_EN
    .fail_valid(fail_valid2), .fail_addr(fail_addr2), .fail_exp(fail_exp2), .fail_act(fail_act2),
`endif
    .ram(bus2)
  );

  // RAM models: 1-cycle for dut (with fault injection), 2-cycle fault-free for dut2.
  logic [17:0] mem [DEPTH];
  logic [17:0] mem2 [DEPTH];
  logic [17:0] rd1_q, rd2a_q, rd2b_q;

  function automatic logic [17:0] faulty(input logic [17:0] w, input logic [9:0] a);
    logic [17:0] r;
    r = w;
    if (fault_d0) r[0] = 1'b0;
    if (fault_par && (a == 10'h155 || a == 10'h200)) r[17] = ~r[17];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.wen_a) mem[bus.addr_a[13:4]] <= {bus.wparity_a, bus.wdata_a};
    if (bus.ren_b) rd1_q <= faulty(mem[bus.addr_b[13:4]], bus.addr_b[13:4]);
    if (bus2.wen_a) mem2[bus2.addr_a[13:4]] <= {bus2.wparity_a, bus2.wdata_a};
    if (bus2.ren_b) rd2a_q <= mem2[bus2.addr_b[13:4]];
    rd2b_q <= rd2a_q;
  end

  assign bus.rdata_b    = rd1_q[15:0];
  assign bus.rparity_b  = rd1_q[17:16];
  assign bus2.rdata_b   = rd2b_q[15:0];
  assign bus2.rparity_b = rd2b_q[17:16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected write stream {be, addr, parity, data} for one run.
  task automatic push_writes(input logic [15:0] s);
    logic [15:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'(i) ^ s;
      wr_q.push_back({2'b11, 14'(i * 16), ^d[15:8], ^d[7:0], d});
    end
  endtask

  // Write scoreboard and idle-port checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wen_a) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_q.size()), 64'd1);
        else check("wr_word", {bus.be_a, bus.addr_a, bus.wparity_a, bus.wdata_a}, wr_q.pop_front());
      end else begin
        check("idle_a", {bus.be_a, bus.addr_a, bus.wparity_a, bus.wdata_a}, 64'd0);
      end
      if (!bus.ren_b) check("idle_b", bus.addr_b, 64'd0);
    end
  end

  // Full run on dut; optional probe of the idx=3 write for seed A5A5.
  task automatic run_test(input logic [15:0] s, input int exp_errs, input bit probe);
    run_exp_t e;
    int cyc;
    e.lat  = 2 * DEPTH + 2;
    e.errs = exp_errs;
    e.ok   = (exp_errs == 0);
    run_q.push_back(e);
    push_writes(s);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", busy, 1);
    check("done_cleared", done, 0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (probe && cyc == 4) begin
        check("probe_addr", bus.addr_a, 14'h0030);
        check("probe_wdata", bus.wdata_a, 16'hA5A6);
        check("probe_par", bus.wparity_a, 2'b00);
        check("probe_be", bus.be_a, 2'b11);
      end
    end
    e = run_q.pop_front();
    check("latency", cyc, e.lat);
    check("err_cnt", err_cnt, e.errs);
    check("pass", pass, e.ok);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, pass, err_cnt, bus.wen_a, bus.ren_b, bus.be_a}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {busy, done, pass, err_cnt, bus.wen_a, bus.ren_b}, 64'd0);

    // Fault-free runs, back to back from DONE.
    run_test(16'h0000, 0, 1'b0);
    run_test(16'hA5A5, 0, 1'b1);

    // Stuck-at-0 data bit: every odd word mismatches.
    fault_d0 = 1'b1;
    run_test(16'h0000, 512, 1'b0);
    fault_d0 = 1'b0;
    repeat (5) @(negedge clk);
    check("done_held", done, 1);
    check("err_held", err_cnt, 512);

    // START while busy is ignored; reset mid-write aborts.
    push_writes(16'h1234);
    seed  = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = 16'hFFFF;
    repeat (51) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore", busy, 1);
    check("done_ignore", done, 0);
    repeat (49) @(negedge clk);
    check("idx100_addr", bus.addr_a, 14'(100 * 16));
    #2 rst_n = 1'b0;
    #1 check("rst_async", {busy, done, pass, err_cnt, bus.wen_a, bus.ren_b, bus.be_a,
                           bus.addr_a, bus.wparity_a, bus.wdata_a}, 64'd0);
    check("rst_async_b", bus.addr_b, 64'd0);
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(16'h0F0F, 0, 1'b0);

    // Parity bit 17 flipped on two words.
    fault_par = 1'b1;
    run_test(16'h0000, 2, 1'b0);
    fault_par = 1'b0;
`ifdef TDP_BIST_ERR_LOG_EN
    check("fail_valid", fail_valid, 1);
    check("fail_addr", fail_addr, 10'h155);
    check("fail_exp", fail_exp, 18'h20155);
    check("fail_diff", fail_exp ^ fail_act, 18'h20000);
`endif

    // Two-cycle read latency instance.
    seed2  = 16'h5A5A;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("lat2_latency", cyc, 2 * DEPTH + 3);
    check("lat2_err_cnt", err_cnt2, 0);
    check("lat2_pass", pass2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
